// File: rtl/alu_cmd_issuer_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer_if
//   Command push channel into the ALU command issuer.
//   Handshake: a command transfers on a rising clk edge where cmd_valid and
//   cmd_ready are both 1. While cmd_valid=1 and cmd_ready=0, the source holds
//   cmd_op/cmd_a/cmd_b stable until the transfer happens.
//   Signals:
//     cmd_valid  source -> issuer  command push request
//     cmd_ready  issuer -> source  push accepted this edge when high
//     cmd_op     source -> issuer  0=add 1=sub 2=and 3=or
//     cmd_a      source -> issuer  operand A
//     cmd_b      source -> issuer  operand B
// ---------------------------------------------------------------------------
interface alu_cmd_issuer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;

  modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_a, cmd_b, output cmd_ready);
endinterface

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
//   Initiator side of a 4-bit registered ALU. Buffers up to DEPTH commands,
//   and on start issues them one at a time (alu_en for one cycle, then LAT
//   wait cycles), captures alu_ans and compares it against a 4-bit reference
//   model, counting mismatches.
// Parameters:
//   DEPTH  queue entries (power of 2, >= 2)
//   LAT    cycles from the alu_en=1 cycle until alu_ans is valid (>= 1)
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   cmd             command push channel (slave side)
//   start           begin issuing the queued batch (sampled only in IDLE)
//   busy            1 while in ISSUE/WAIT
//   done            1-cycle pulse when a batch completes
//   alu_a/b/op/en   registered drive to the ALU
//   alu_ans         ALU result
//   res_valid       1-cycle pulse, res_data/res_err valid
//   res_data        captured alu_ans
//   res_err         res_data differs from the reference model
//   err_cnt         saturating mismatch count, cleared on accepted start
//   q_count         entries currently queued
//   o_dbg_state     FSM state (0=IDLE 1=ISSUE 2=WAIT)
// ---------------------------------------------------------------------------
module alu_cmd_issuer #(
  parameter int DEPTH = 8,
  parameter int LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  alu_cmd_issuer_if.slave              cmd,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [3:0]                   alu_a,
  output logic [3:0]                   alu_b,
  output logic [1:0]                   alu_op,
  output logic                         alu_en,
  input  logic [3:0]                   alu_ans,
  output logic                         res_valid,
  output logic [3:0]                   res_data,
  output logic                         res_err,
  output logic [3:0]                   err_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic [1:0]                   o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = $clog2(LAT+1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  state_t          r_state;
  state_t          w_state_nxt;
  cmd_t            r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [LW-1:0]   r_wait_cnt;
  logic [3:0]      r_alu_a;
  logic [3:0]      r_alu_b;
  logic [1:0]      r_alu_op;
  logic            r_alu_en;
  logic            r_res_valid;
  logic [3:0]      r_res_data;
  logic            r_res_err;
  logic [3:0]      r_err_cnt;
  logic            r_done;

  logic            w_push;
  logic            w_pop;
  logic            w_last_wait;
  logic            w_start_go;
  logic            w_empty_start;
  logic            w_load;
  logic            w_mismatch;
  logic [AW-1:0]   w_rd_sel;
  cmd_t            w_cmd_in;
  cmd_t            w_head;
  logic [3:0]      w_model;

  assign cmd.cmd_ready = (r_state == S_IDLE) && (r_count < CW'(DEPTH));
  assign w_push        = cmd.cmd_valid && cmd.cmd_ready;
  assign w_cmd_in      = '{op: cmd.cmd_op, a: cmd.cmd_a, b: cmd.cmd_b};

  assign w_last_wait   = (r_state == S_WAIT) && (r_wait_cnt == LW'(1));
  assign w_pop         = w_last_wait;
  // A push in the same cycle as start joins the batch, so an empty queue
  // plus a push still starts issuing.
  assign w_start_go    = (r_state == S_IDLE) && start && ((r_count != '0) || w_push);
  assign w_empty_start = (r_state == S_IDLE) && start && !w_start_go;
  assign w_load        = (w_state_nxt == S_ISSUE);

  // The ALU drive registers are loaded on the edge entering ISSUE, so the
  // head must be looked up one step ahead: past the entry being popped, or
  // straight from the push bus when the queue is empty.
  assign w_rd_sel = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
  assign w_head   = (r_count == '0) ? w_cmd_in : r_mem[w_rd_sel];

  // Reference model, evaluated on the held ALU operands.
  always_comb begin
    w_model = 4'h0;
    unique case (r_alu_op)
      2'd0:    w_model = r_alu_a + r_alu_b;
      2'd1:    w_model = r_alu_a - r_alu_b;
      2'd2:    w_model = r_alu_a & r_alu_b;
      default: w_model = r_alu_a | r_alu_b;
    endcase
  end

  assign w_mismatch = (alu_ans != w_model);

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_go) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_last_wait) w_state_nxt = (r_count > CW'(1)) ? S_ISSUE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Queue storage carries no reset; validity lives in the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_cmd_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      // Push happens only in IDLE and pop only in WAIT, never together.
      if (w_push)     r_count <= r_count + CW'(1);
      else if (w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_alu_en   <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wait_cnt <= LW'(LAT);
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt - LW'(1);
      r_alu_en <= w_load;
      if (w_load) begin
        r_alu_a  <= w_head.a;
        r_alu_b  <= w_head.b;
        r_alu_op <= w_head.op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_err_cnt   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_res_valid <= w_pop;
      r_res_err   <= w_pop && w_mismatch;
      if (w_pop) r_res_data <= alu_ans;
      if (w_start_go)
        r_err_cnt <= '0;
      else if (w_pop && w_mismatch && (r_err_cnt != 4'hF))
        r_err_cnt <= r_err_cnt + 4'd1;
      // Done comes with the final result, or one cycle after an empty start.
      r_done <= w_empty_start || (w_pop && (r_count == CW'(1)));
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign alu_en      = r_alu_en;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_err     = r_res_err;
  assign err_cnt     = r_err_cnt;
  assign q_count     = r_count;
  assign o_dbg_state = r_state;

endmodule
